// File: rtl/btn_conditioner.sv
// Five-key debounce and event extraction: clean levels, press/release pulses, long-press pulse.
// Define BTN_LONG_PRESS_EN to build the per-key hold timers; otherwise btn_long is tied low.
module btn_conditioner #(
  parameter int unsigned NUM_BTN     = 5,
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 3000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic               ms_tick
);

  localparam int unsigned TICK_CYC = CLK_HZ / 1000;
  localparam int unsigned PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int unsigned DB_W     = 8;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_MS - 1);

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [PRE_W-1:0]   r_pre;
  logic               r_tick;
  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] r_level_d;
  logic [NUM_BTN-1:0] r_press;
  logic [NUM_BTN-1:0] r_release;

  // Two-flop synchronizer; the only consumer of btn_raw.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Shared 1 ms prescaler; strobe is registered and lands on the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else if (r_pre == PRE_LAST) begin
      r_pre  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_pre  <= r_pre + PRE_W'(1);
      r_tick <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    logic [DB_W-1:0] r_db;
    logic            r_level;

    // Any agreement with the synchronized input wipes the count.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_db    <= '0;
        r_level <= 1'b0;
      end else if (r_sync2[g] == r_level) begin
        r_db <= '0;
      end else if (r_tick) begin
        if (r_db == DB_LAST) begin
          r_db    <= '0;
          r_level <= ~r_level;
        end else begin
          r_db <= r_db + DB_W'(1);
        end
      end
    end

    assign w_level[g] = r_level;

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned HOLD_W = 16;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_MS);

    logic [HOLD_W-1:0] r_hold;
    logic              r_sat_d;
    logic              r_long;

    // Saturating hold timer; the pulse fires once on the first cycle at saturation.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_hold  <= '0;
        r_sat_d <= 1'b0;
        r_long  <= 1'b0;
      end else begin
        if (!r_level) begin
          r_hold <= '0;
        end else if (r_tick && (r_hold != HOLD_MAX)) begin
          r_hold <= r_hold + HOLD_W'(1);
        end
        r_sat_d <= (r_hold == HOLD_MAX);
        r_long  <= (r_hold == HOLD_MAX) && !r_sat_d;
      end
    end

    assign btn_long[g] = r_long;
`endif
  end

`ifndef BTN_LONG_PRESS_EN
  // LONG_MS has no effect in this build.
  assign btn_long = (LONG_MS > 0) ? '0 : '0;
`endif

  // Registered edge detect of the debounced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level_d <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_level_d <= w_level;
      r_press   <= w_level & ~r_level_d;
      r_release <= ~w_level & r_level_d;
    end
  end

  assign btn_level   = w_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign ms_tick     = r_tick;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner at CLK_HZ=10_000 (tick every 10 cycles), DEBOUNCE_MS=3, LONG_MS=10.
module tb_btn_conditioner;

  localparam int N = 5;
`ifdef BTN_LONG_PRESS_EN
  localparam int EXP_LONG = 1;
`else
  localparam int EXP_LONG = 0;
`endif
  localparam int K_LVL = 0;
  localparam int K_PRS = 1;
  localparam int K_REL = 2;
  localparam int K_LNG = 3;
  localparam int K_TCK = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_long;
  logic         ms_tick;

  btn_conditioner #(
    .NUM_BTN    (N),
    .CLK_HZ     (10_000),
    .DEBOUNCE_MS(3),
    .LONG_MS    (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long),
    .ms_tick    (ms_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse bookkeeping sampled on the active edge.
  int cyc = 0;
  int press_cnt[N]   = '{default: 0};
  int release_cnt[N] = '{default: 0};
  int long_cnt[N]    = '{default: 0};
  int press_cyc[N]   = '{default: 0};
  int long_cyc[N]    = '{default: 0};
  logic [N-1:0] prev_p = '0;
  logic [N-1:0] prev_r = '0;
  logic [N-1:0] prev_l = '0;
  logic         prev_t = 1'b0;
  int wide = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (btn_press[i]) begin
        press_cnt[i] <= press_cnt[i] + 1;
        press_cyc[i] <= cyc;
      end
      if (btn_release[i]) release_cnt[i] <= release_cnt[i] + 1;
      if (btn_long[i]) begin
        long_cnt[i] <= long_cnt[i] + 1;
        long_cyc[i] <= cyc;
      end
    end
    if ((|(btn_press & prev_p)) || (|(btn_release & prev_r)) ||
        (|(btn_long & prev_l)) || (ms_tick && prev_t))
      wide <= wide + 1;
    prev_p <= btn_press;
    prev_r <= btn_release;
    prev_l <= btn_long;
    prev_t <= ms_tick;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int kind, input int idx);
    case (kind)
      K_LVL:   return btn_level[idx];
      K_PRS:   return btn_press[idx];
      K_REL:   return btn_release[idx];
      K_LNG:   return btn_long[idx];
      default: return ms_tick;
    endcase
  endfunction

  // Returns the number of falling edges until the selected bit is seen high, or -1 on timeout.
  task automatic wait_bit(input int kind, input int idx, input int max, output int n);
    n = -1;
    for (int c = 1; c <= max; c++) begin
      @(negedge clk);
      if (pick(kind, idx)) begin
        n = c;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int lc;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({btn_level, btn_press, btn_release, btn_long, ms_tick}), 0);
    rst = 1'b0;

    // Prescaler: first strobe 10 cycles after reset release, one cycle wide, period 10
    wait_bit(K_TCK, 0, 20, n);
    chk("first_tick_latency", n, 10);
    @(negedge clk);
    chk("tick_width", 32'(ms_tick), 0);
    wait_bit(K_TCK, 0, 20, n);
    chk("tick_period", n, 9);

    // Clean press on middle key
    btn_raw[2] = 1'b1;
    wait_bit(K_LVL, 2, 40, n);
    chk("press_level_latency_ok", 32'(n >= 23 && n <= 32), 1);
    chk("press_not_yet", 32'(btn_press), 0);
    @(negedge clk);
    chk("press_pulse", 32'(btn_press), 32'b00100);
    @(negedge clk);
    chk("press_width", 32'(btn_press), 0);
    chk("level_only_bit2", 32'(btn_level), 32'b00100);

    // Release of middle key
    btn_raw[2] = 1'b0;
    wait_bit(K_REL, 2, 40, n);
    chk("release_latency_ok", 32'(n >= 24 && n <= 33), 1);
    chk("release_pulse", 32'(btn_release), 32'b00100);
    chk("release_level", 32'(btn_level), 0);
    @(negedge clk);
    chk("release_width", 32'(btn_release), 0);

    // 15-cycle glitch on up key
    btn_raw[0] = 1'b1;
    repeat (15) @(negedge clk);
    btn_raw[0] = 1'b0;
    repeat (40) @(negedge clk);
    chk("glitch_level", 32'(btn_level), 0);
    chk("glitch_press", press_cnt[0], 0);
    chk("glitch_release", release_cnt[0], 0);

    // Long hold on left key for 200 cycles
    btn_raw[1] = 1'b1;
    wait_bit(K_PRS, 1, 40, n);
    chk("long_press_latency_ok", 32'(n >= 24 && n <= 33), 1);
    repeat (200 - n) @(negedge clk);
    chk("long_count", long_cnt[1], EXP_LONG);
`ifdef BTN_LONG_PRESS_EN
    chk("long_gap_ok", 32'((long_cyc[1] - press_cyc[1]) >= 90 && (long_cyc[1] - press_cyc[1]) <= 111), 1);
`endif
    btn_raw[1] = 1'b0;
    wait_bit(K_REL, 1, 40, n);
    chk("long_release_latency_ok", 32'(n >= 24 && n <= 33), 1);
    repeat (5) @(negedge clk);
    chk("long_release_count", release_cnt[1], 1);
    chk("long_no_repeat", long_cnt[1], EXP_LONG);

    // Simultaneous right and down
    btn_raw[4:3] = 2'b11;
    wait_bit(K_PRS, 3, 40, n);
    chk("simul_press", 32'(btn_press), 32'b11000);
    btn_raw[4:3] = 2'b00;
    wait_bit(K_REL, 3, 40, n);
    chk("simul_release", 32'(btn_release), 32'b11000);

    // Reset in the middle of a hold
    btn_raw[2] = 1'b1;
    wait_bit(K_PRS, 2, 40, n);
    chk("midhold_press_seen", 32'(n != -1), 1);
    for (int k = 0; k < 5; k++) wait_bit(K_TCK, 0, 12, n);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", 32'({btn_level, btn_press, btn_release, btn_long, ms_tick}), 0);
    rst = 1'b0;
    lc = long_cnt[2];
    wait_bit(K_PRS, 2, 40, n);
    chk("repress_latency", n, 32);
    repeat (90) @(negedge clk);
    chk("no_early_long", long_cnt[2], lc);
    wait_bit(K_LNG, 2, 30, n);
    chk("long_after_reset", 32'(n != -1), EXP_LONG);
    btn_raw[2] = 1'b0;
    wait_bit(K_REL, 2, 40, n);
    chk("midhold_release_seen", 32'(n != -1), 1);
    repeat (5) @(negedge clk);

    // Global pulse properties
    chk("pulse_width_violations", wide, 0);
    chk("stray_long", long_cnt[0] + long_cnt[3] + long_cnt[4], 0);
    chk("press_counts", press_cnt[1] + press_cnt[3] + press_cnt[4], 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
